// File: rtl/regfile_arb_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] regIdx;
        logic [DEF_DATA_W-1:0] data;
    } wrReq_t;

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// DEPTH-entry synchronous FIFO for one writeback source; exposes every slot
// and its valid bit so the parent can build the pending-write mask.
module wb_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [W-1:0]              pushData,
    input  logic                      pop,
    output logic                      full,
    output logic                      empty,
    output logic [W-1:0]              head,
    output logic [DEPTH-1:0]          entryValid,
    output logic [DEPTH-1:0][W-1:0]   entries
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]        wrPtr, rdPtr;
    logic [DEPTH-1:0]        validQ;
    logic [DEPTH-1:0][W-1:0] mem;

    // NOTE: storage has no reset; validQ alone says which slots mean anything.
    always_ff @(posedge clk) begin
        if (push) mem[wrPtr] <= pushData;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // always_ff sees pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            validQ <= '0;
        end else begin
            if (pop) begin
                validQ[rdPtr] <= 1'b0;
                rdPtr         <= rdPtr + 1'b1;
            end
            // A push into the slot being popped (full FIFO) must win.
            if (push) begin
                validQ[wrPtr] <= 1'b1;
                wrPtr         <= wrPtr + 1'b1;
            end
        end
    end

    assign full       = &validQ;
    assign empty      = ~|validQ;
    assign head       = mem[rdPtr];
    assign entryValid = validQ;
    assign entries    = mem;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-source register-file write arbiter: per-source FIFOs, round-robin grant,
// registered write stage, pending mask. REGFILE_ARB_FIXED_PRIO_EN gives src0 fixed priority.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s0_valid,
    output logic                  s0_ready,
    input  logic [ADDR_W-1:0]     s0_reg,
    input  logic [DATA_W-1:0]     s0_data,
    input  logic                  s1_valid,
    output logic                  s1_ready,
    input  logic [ADDR_W-1:0]     s1_reg,
    input  logic [DATA_W-1:0]     s1_data,
    output logic [ADDR_W-1:0]     writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic                  regWrite,
    output logic [2**ADDR_W-1:0]  pending,
    output logic                  idle
);

    localparam int W = ADDR_W + DATA_W;

    logic                    push0, push1, pop0, pop1;
    logic                    full0, full1, empty0, empty1;
    logic [W-1:0]            head0, head1, grantReq;
    logic [DEPTH-1:0]        valid0, valid1;
    logic [DEPTH-1:0][W-1:0] entries0, entries1;
    logic                    grant;
    logic [ADDR_W-1:0]       grantRegIdx;
    src_e                    winner;

    assign s0_ready = !full0;
    assign s1_ready = !full1;
    assign push0    = s0_valid && s0_ready;
    assign push1    = s1_valid && s1_ready;

    wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
        .clk(clk), .rst_n(rst_n), .push(push0), .pushData({s0_reg, s0_data}),
        .pop(pop0), .full(full0), .empty(empty0), .head(head0),
        .entryValid(valid0), .entries(entries0)
    );

    wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .rst_n(rst_n), .push(push1), .pushData({s1_reg, s1_data}),
        .pop(pop1), .full(full1), .empty(empty1), .head(head1),
        .entryValid(valid1), .entries(entries1)
    );

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign winner = empty0 ? SRC1 : SRC0;
`else
    src_e rrPtr;

    assign winner = (!empty0 && !empty1) ? rrPtr : (empty0 ? SRC1 : SRC0);

    // The pointer only turns over when both heads competed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                rrPtr <= SRC0;
        else if (!empty0 && !empty1) rrPtr <= (winner == SRC0) ? SRC1 : SRC0;
    end
`endif

    assign grant       = !empty0 || !empty1;
    assign pop0        = grant && (winner == SRC0);
    assign pop1        = grant && (winner == SRC1);
    assign grantReq    = (winner == SRC0) ? head0 : head1;
    assign grantRegIdx = grantReq[W-1:DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeReg  <= '0;
            writeData <= '0;
            regWrite  <= 1'b0;
        end else if (grant) begin
            writeReg  <= grantRegIdx;
            writeData <= grantReq[DATA_W-1:0];
            regWrite  <= (grantRegIdx != '0);
        end else begin
            regWrite  <= 1'b0;
        end
    end

    // NOTE: pending gets a full default before the loop so no bit can
    // hold its value and infer a latch.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid0[i]) pending[entries0[i][W-1:DATA_W]] = 1'b1;
            if (valid1[i]) pending[entries1[i][W-1:DATA_W]] = 1'b1;
        end
        if (regWrite) pending[writeReg] = 1'b1;
        pending[0] = 1'b0;
    end

    assign idle = empty0 && empty1 && !regWrite;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (default or
// REGFILE_ARB_FIXED_PRIO_EN build).
module tb_regfile_write_arbiter;
    import regfile_arb_pkg::*;

    localparam int ADDR_W = DEF_ADDR_W;
    localparam int DATA_W = DEF_DATA_W;

    logic                 clk, rst_n;
    logic                 s0_valid, s0_ready, s1_valid, s1_ready;
    logic [ADDR_W-1:0]    s0_reg, s1_reg, writeReg;
    logic [DATA_W-1:0]    s0_data, s1_data, writeData;
    logic                 regWrite, idle;
    logic [2**ADDR_W-1:0] pending;

    int checks = 0;
    int errors = 0;

    wrReq_t wlog[$];
    wrReq_t in0[$], in1[$];
    bit     rdy0Log[$], rdy1Log[$];

    regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_reg(s0_reg), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_reg(s1_reg), .s1_data(s1_data),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite),
        .pending(pending), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && regWrite) wlog.push_back({writeReg, writeData});
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic wrReq_t mk(input int r, input int d);
        mk.regIdx = ADDR_W'(r);
        mk.data   = DATA_W'(d);
    endfunction

    task automatic apply_reset();
        s0_valid = 1'b0; s0_reg = '0; s0_data = '0;
        s1_valid = 1'b0; s1_reg = '0; s1_data = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wlog.delete(); in0.delete(); in1.delete();
        rdy0Log.delete(); rdy1Log.delete();
    endtask

    // Drives in0/in1 as continuously valid streams, then waits for idle.
    task automatic run_streams();
        int  i0 = 0, i1 = 0, cyc = 0;
        bit  acc0, acc1;
        while ((i0 < in0.size() || i1 < in1.size()) && cyc < 200) begin
            @(negedge clk);
            s0_valid = (i0 < in0.size());
            s1_valid = (i1 < in1.size());
            if (s0_valid) begin {s0_reg, s0_data} = in0[i0]; rdy0Log.push_back(s0_ready); end
            if (s1_valid) begin {s1_reg, s1_data} = in1[i1]; rdy1Log.push_back(s1_ready); end
            acc0 = s0_valid && s0_ready;
            acc1 = s1_valid && s1_ready;
            @(posedge clk);
            if (acc0) i0++;
            if (acc1) i1++;
            cyc++;
        end
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d/%0d and %0d/%0d", i0, in0.size(), i1, in1.size());
        end
        @(negedge clk);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        cyc = 0;
        while (!idle && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL drain_timeout: idle=%b required 1", idle);
        end
    endtask

    task automatic test_reset();
        s0_valid = 1'b0; s0_reg = '0; s0_data = '0;
        s1_valid = 1'b0; s1_reg = '0; s1_data = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL rst_regWrite: got %b required 0", regWrite); end
        checks++; if (writeReg !== '0)   begin errors++; $display("FAIL rst_writeReg: got %0d required 0", writeReg); end
        checks++; if (writeData !== '0)  begin errors++; $display("FAIL rst_writeData: got %h required 0", writeData); end
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready: got %b%b required 11", s0_ready, s1_ready);
        end
        checks++; if (pending !== '0)    begin errors++; $display("FAIL rst_pending: got %h required 0", pending); end
        checks++; if (idle !== 1'b1)     begin errors++; $display("FAIL rst_idle: got %b required 1", idle); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        s0_valid = 1'b1; s0_reg = 5'd3; s0_data = 32'h5;
        @(posedge clk);
        @(negedge clk);
        s0_valid = 1'b0;
        checks++; if (pending !== 32'h8) begin errors++; $display("FAIL single_pend_queued: got %h required 8", pending); end
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL single_rw_early: got %b required 0", regWrite); end
        checks++; if (idle !== 1'b0)     begin errors++; $display("FAIL single_idle_busy: got %b required 0", idle); end
        @(negedge clk);
        checks++; if (regWrite !== 1'b1) begin errors++; $display("FAIL single_rw: got %b required 1", regWrite); end
        checks++; if (writeReg !== 5'd3) begin errors++; $display("FAIL single_reg: got %0d required 3", writeReg); end
        checks++; if (writeData !== 32'h5) begin errors++; $display("FAIL single_data: got %h required 5", writeData); end
        checks++; if (pending !== 32'h8) begin errors++; $display("FAIL single_pend_staged: got %h required 8", pending); end
        @(negedge clk);
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL single_rw_done: got %b required 0", regWrite); end
        checks++; if (pending !== '0)    begin errors++; $display("FAIL single_pend_clear: got %h required 0", pending); end
        checks++; if (idle !== 1'b1)     begin errors++; $display("FAIL single_idle_done: got %b required 1", idle); end
    endtask

    task automatic test_round_robin();
        wrReq_t exp[$];
        wrReq_t got;
        apply_reset();
        in0.push_back(mk(1, 'h11)); in0.push_back(mk(2, 'h22));
        in1.push_back(mk(4, 'h44)); in1.push_back(mk(5, 'h55));
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        exp.push_back(mk(1, 'h11)); exp.push_back(mk(2, 'h22));
        exp.push_back(mk(4, 'h44)); exp.push_back(mk(5, 'h55));
`else
        exp.push_back(mk(1, 'h11)); exp.push_back(mk(4, 'h44));
        exp.push_back(mk(2, 'h22)); exp.push_back(mk(5, 'h55));
`endif
        run_streams();
        checks++;
        if (wlog.size() != exp.size()) begin
            errors++; $display("FAIL rr_count: got %0d writes required %0d", wlog.size(), exp.size());
        end
        foreach (exp[i]) begin
            got = (i < wlog.size()) ? wlog[i] : '0;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL rr_order[%0d]: got reg %0d data %h required reg %0d data %h",
                                   i, got.regIdx, got.data, exp[i].regIdx, exp[i].data);
            end
        end
    endtask

    task automatic test_backpressure();
        wrReq_t exp[$];
        wrReq_t got;
        bit     expRdy[$];
        apply_reset();
        for (int i = 0; i < 6; i++) in0.push_back(mk(10 + i, 'hA0 + i));
        for (int i = 0; i < 3; i++) in1.push_back(mk(20 + i, 'hB0 + i));
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        for (int i = 0; i < 6; i++) exp.push_back(in0[i]);
        for (int i = 0; i < 3; i++) exp.push_back(in1[i]);
        expRdy = '{1, 1, 0, 0, 0, 0, 0, 0, 1};
`else
        exp = '{in0[0], in1[0], in0[1], in1[1], in0[2], in1[2], in0[3], in0[4], in0[5]};
        expRdy = '{1, 1, 0, 1};
`endif
        run_streams();
        checks++;
        if (wlog.size() != exp.size()) begin
            errors++; $display("FAIL bp_count: got %0d writes required %0d", wlog.size(), exp.size());
        end
        foreach (exp[i]) begin
            got = (i < wlog.size()) ? wlog[i] : '0;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL bp_order[%0d]: got reg %0d data %h required reg %0d data %h",
                                   i, got.regIdx, got.data, exp[i].regIdx, exp[i].data);
            end
        end
        checks++;
        if (rdy1Log.size() != expRdy.size()) begin
            errors++; $display("FAIL bp_ready_len: got %0d cycles required %0d", rdy1Log.size(), expRdy.size());
        end
        foreach (expRdy[i]) begin
            checks++;
            if (i >= rdy1Log.size() || rdy1Log[i] !== expRdy[i]) begin
                errors++; $display("FAIL bp_s1_ready[%0d]: got %b required %b", i,
                                   (i < rdy1Log.size()) ? rdy1Log[i] : 1'bx, expRdy[i]);
            end
        end
    endtask

    task automatic test_reg_zero();
        apply_reset();
        s0_valid = 1'b1; s0_reg = 5'd0; s0_data = 32'hFFFF;
        @(posedge clk);
        @(negedge clk);
        s0_valid = 1'b0;
        checks++; if (pending !== '0)    begin errors++; $display("FAIL r0_pend_queued: got %h required 0", pending); end
        checks++; if (idle !== 1'b0)     begin errors++; $display("FAIL r0_idle_queued: got %b required 0", idle); end
        @(negedge clk);
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL r0_regWrite: got %b required 0", regWrite); end
        checks++; if (writeData !== 32'hFFFF) begin errors++; $display("FAIL r0_data: got %h required ffff", writeData); end
        checks++; if (idle !== 1'b1)     begin errors++; $display("FAIL r0_consumed: idle got %b required 1", idle); end
        checks++; if (pending !== '0)    begin errors++; $display("FAIL r0_pend: got %h required 0", pending); end
        checks++; if (wlog.size() != 0)  begin errors++; $display("FAIL r0_writes: got %0d required 0", wlog.size()); end
    endtask

    task automatic test_push_pop_full();
        wrReq_t exp[$];
        wrReq_t got;
        bit     expRdy[$];
        apply_reset();
        for (int i = 0; i < 4; i++) in0.push_back(mk(10 + i, 'hC0 + i));
        for (int i = 0; i < 2; i++) in1.push_back(mk(20 + i, 'hD0 + i));
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        exp = '{in0[0], in0[1], in0[2], in0[3], in1[0], in1[1]};
        expRdy = '{1, 1, 1, 1};
`else
        exp = '{in0[0], in1[0], in0[1], in1[1], in0[2], in0[3]};
        expRdy = '{1, 1, 1, 0, 1};
`endif
        run_streams();
        checks++;
        if (wlog.size() != exp.size()) begin
            errors++; $display("FAIL pp_count: got %0d writes required %0d", wlog.size(), exp.size());
        end
        foreach (exp[i]) begin
            got = (i < wlog.size()) ? wlog[i] : '0;
            checks++;
            if (got !== exp[i]) begin
                errors++; $display("FAIL pp_order[%0d]: got reg %0d data %h required reg %0d data %h",
                                   i, got.regIdx, got.data, exp[i].regIdx, exp[i].data);
            end
        end
        foreach (expRdy[i]) begin
            checks++;
            if (i >= rdy0Log.size() || rdy0Log[i] !== expRdy[i]) begin
                errors++; $display("FAIL pp_s0_ready[%0d]: got %b required %b", i,
                                   (i < rdy0Log.size()) ? rdy0Log[i] : 1'bx, expRdy[i]);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        s0_valid = 1'b1; s0_reg = 5'd1; s0_data = 32'h1;
        s1_valid = 1'b1; s1_reg = 5'd3; s1_data = 32'h3;
        @(posedge clk);
        @(negedge clk);
        s0_reg = 5'd2; s0_data = 32'h2;
        s1_reg = 5'd4; s1_data = 32'h4;
        @(posedge clk);
        @(negedge clk);
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        checks++; if (pending !== 32'h1E) begin errors++; $display("FAIL mid_pend_before: got %h required 1e", pending); end
        checks++; if (regWrite !== 1'b1)  begin errors++; $display("FAIL mid_rw_before: got %b required 1", regWrite); end
        checks++; if (s1_ready !== 1'b0)  begin errors++; $display("FAIL mid_s1_full: got %b required 0", s1_ready); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (regWrite !== 1'b0) begin errors++; $display("FAIL mid_rw_async: got %b required 0", regWrite); end
        checks++; if (pending !== '0)    begin errors++; $display("FAIL mid_pend_async: got %h required 0", pending); end
        checks++; if (idle !== 1'b1)     begin errors++; $display("FAIL mid_idle_async: got %b required 1", idle); end
        checks++; if (writeReg !== '0)   begin errors++; $display("FAIL mid_writeReg_async: got %0d required 0", writeReg); end
        @(negedge clk);
        rst_n = 1'b1;
        wlog.delete();
        checks++; if (s0_ready !== 1'b1 || s1_ready !== 1'b1) begin
            errors++; $display("FAIL mid_ready_after: got %b%b required 11", s0_ready, s1_ready);
        end
        repeat (5) @(negedge clk);
        checks++; if (wlog.size() != 0) begin errors++; $display("FAIL mid_stale_writes: got %0d required 0", wlog.size()); end
        checks++; if (idle !== 1'b1)    begin errors++; $display("FAIL mid_idle_after: got %b required 1", idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reg_zero();
        test_push_pop_full();
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
